// File: rtl/product_accumulator.sv
// Frame accumulator behind the signed multiplier: sums COUNT products, then holds the result.
// Define PRODUCT_ACCUMULATOR_SATURATE_EN to clamp on overflow instead of wrapping.
module product_accumulator #(
  parameter int WIDTH       = 8,
  parameter int ACC_WIDTH   = 24,
  parameter int COUNT       = 16,
  parameter int COUNT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2*WIDTH-1:0]     product_in,
  input  logic                   product_valid,
  output logic                   product_ready,
  output logic [ACC_WIDTH-1:0]   acc_out,
  output logic                   acc_valid,
  input  logic                   acc_ready,
  output logic                   busy,
  output logic                   overflow
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_e;

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   vld_q, vld_d;

  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH:0]          sum;
  logic                        add_ovf;
  logic                        xfer;
  logic                        last;

  assign prod_ext = ACC_WIDTH'($signed(product_in));
  assign sum      = {acc_q[ACC_WIDTH-1], acc_q}
                  + {prod_ext[ACC_WIDTH-1], prod_ext};
  // Extended sign bit disagreeing with the result MSB is signed overflow.
  assign add_ovf  = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];

  assign product_ready = (state_q == ACCUM);
  assign busy          = (state_q != IDLE);
  assign xfer          = product_valid & product_ready;
  assign last          = (cnt_q == COUNT_WIDTH'(COUNT - 1));

  assign acc_out   = acc_q;
  assign acc_valid = vld_q;
  assign overflow  = ovf_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    vld_d   = vld_q;
    unique case (state_q)
      IDLE: begin
        vld_d = 1'b0;
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (xfer) begin
          cnt_d = cnt_q + 1'b1;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
          if (add_ovf)
            acc_d = sum[ACC_WIDTH]
                  ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                  : {1'b0, {(ACC_WIDTH-1){1'b1}}};
          else
            acc_d = sum[ACC_WIDTH-1:0];
`else
          acc_d = sum[ACC_WIDTH-1:0];
`endif
          if (add_ovf)
            ovf_d = 1'b1;
          if (last) begin
            vld_d   = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (acc_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized bench for product_accumulator against an integer frame-sum model.
// Build with PRODUCT_ACCUMULATOR_SATURATE_EN to check the clamping variant.
module tb_product_accumulator;

  localparam int W  = 8;
  localparam int AW = 16;
  localparam int N  = 4;
  localparam int CW = 3;
  localparam int AMAX = 32767;
  localparam int AMIN = -32768;

  logic          clk = 0;
  logic          rst = 1;
  logic          start = 0;
  logic [2*W-1:0] product_in = '0;
  logic          product_valid = 0;
  logic          product_ready;
  logic [AW-1:0] acc_out;
  logic          acc_valid;
  logic          acc_ready = 0;
  logic          busy;
  logic          overflow;

  int nvec = 0;
  int nerr = 0;
  int macc;
  int movf;

  product_accumulator #(
    .WIDTH(W), .ACC_WIDTH(AW), .COUNT(N), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .product_in(product_in), .product_valid(product_valid),
    .product_ready(product_ready), .acc_out(acc_out),
    .acc_valid(acc_valid), .acc_ready(acc_ready),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void madd(input int p);
    int s;
    s = macc + p;
    if (s > AMAX || s < AMIN) movf = 1;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    if (s > AMAX) s = AMAX;
    if (s < AMIN) s = AMIN;
`else
    if (s > AMAX) s = s - 65536;
    if (s < AMIN) s = s + 65536;
`endif
    macc = s;
  endfunction

  function automatic int rprod();
    int a, b;
    a = int'($urandom_range(0, 255)) - 128;
    b = int'($urandom_range(0, 255)) - 128;
    return a * b;
  endfunction

  task automatic run_frame(input int ps[N], input bit stall);
    int i = 0;
    int cyc = 0;
    int hn;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    macc = 0;
    movf = 0;
    chk("start_busy", busy, 1);
    chk("start_rdy", product_ready, 1);
    chk("start_acc", $signed(acc_out), 0);
    chk("start_ovf", overflow, 0);
    chk("start_vld", acc_valid, 0);
    while (i < N && cyc < 200) begin
      product_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      product_in = product_valid ? 16'(ps[i]) : 16'($urandom);
      start = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      if (product_valid) begin
        madd(ps[i]);
        i++;
      end
      product_valid = 0;
      start = 0;
      cyc++;
      chk("acc", $signed(acc_out), macc);
      chk("ovf", overflow, movf);
      chk("vld", acc_valid, int'(i == N));
      chk("rdy", product_ready, int'(i < N));
    end
    chk("frame_done", i, N);
    hn = stall ? int'($urandom_range(0, 5)) : 0;
    repeat (hn) begin
      start = $urandom_range(0, 1);
      product_valid = 1;
      @(posedge clk); #1;
      start = 0;
      product_valid = 0;
      chk("hold_vld", acc_valid, 1);
      chk("hold_rdy", product_ready, 0);
      chk("hold_busy", busy, 1);
      chk("hold_acc", $signed(acc_out), macc);
    end
    acc_ready = 1;
    start = $urandom_range(0, 1);
    @(posedge clk); #1;
    acc_ready = 0;
    start = 0;
    chk("done_vld", acc_valid, 0);
    chk("done_busy", busy, 0);
    chk("done_rdy", product_ready, 0);
    chk("done_acc", $signed(acc_out), macc);
    chk("done_ovf", overflow, movf);
    product_valid = 1;
    product_in = 16'($urandom);
    @(posedge clk); #1;
    product_valid = 0;
    chk("idle_busy", busy, 0);
    chk("idle_acc", $signed(acc_out), macc);
  endtask

  initial begin
    int ps[N];
    #1;
    chk("rst_acc", $signed(acc_out), 0);
    chk("rst_vld", acc_valid, 0);
    chk("rst_rdy", product_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;

    ps = '{100, -50, 16384, -16384};
    run_frame(ps, 0);
    chk("basic_sum", $signed(acc_out), 50);
    ps = '{16384, 16384, 16384, -1};
    run_frame(ps, 1);
    chk("pos_ovf_flag", overflow, 1);
    ps = '{-16384, -16384, -16384, -16384};
    run_frame(ps, 1);
    chk("neg_ovf_flag", overflow, 1);
    ps = '{1, 1, 1, 1};
    run_frame(ps, 1);
    chk("post_ovf_sum", $signed(acc_out), 4);
    chk("post_ovf_flag", overflow, 0);

    // Abort a frame with reset after three products.
    start = 1;
    @(posedge clk); #1;
    start = 0;
    product_valid = 1;
    product_in = 16'(1000);
    repeat (3) begin
      @(posedge clk); #1;
    end
    product_valid = 0;
    chk("pre_rst_acc", $signed(acc_out), 3000);
    rst = 1;
    #1;
    chk("mid_rst_acc", $signed(acc_out), 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rdy", product_ready, 0);
    chk("mid_rst_vld", acc_valid, 0);
    chk("mid_rst_ovf", overflow, 0);
    #1;
    rst = 0;
    @(posedge clk); #1;
    ps = '{7, -3, 2, 5};
    run_frame(ps, 0);
    chk("fresh_sum", $signed(acc_out), 11);

    repeat (30) begin
      for (int k = 0; k < N; k++) ps[k] = rprod();
      run_frame(ps, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
